// File: rtl/aes_out_xor.sv
`default_nettype none
// ============================================================================
// Module   : aes_out_xor
// Purpose  : Output stage of the AES datapath. On the final-round strobe it
//            applies the last AddRoundKey (text = sa_i ^ w_i) to the whole
//            state, holds the result and streams it out one byte per
//            valid/ready handshake, most-significant byte first.
// Ports    : clk        rising-edge clock
//            rst        synchronous reset, active low
//            done       final-round strobe, captures sa_i ^ w_i
//            sa_i       final round state (byte NB-1 in the top bits)
//            w_i        last round key
//            text_out   current output byte (0 while no block is held)
//            out_valid  text_out holds a valid byte
//            out_ready  consumer accepts the byte when out_valid is high
//            out_last   marks the final byte of a block
//            busy       a block is held and not yet fully unloaded
//            overrun    sticky: a done strobe arrived that could not be taken
// Revision : 1.0 - initial release
// ============================================================================
module aes_out_xor #(
    parameter int NB = 16,
    parameter int BW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             done,
    input  logic [NB*BW-1:0] sa_i,
    input  logic [NB*BW-1:0] w_i,
    output logic [BW-1:0]    text_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             busy,
    output logic             overrun
);

    localparam int              c_DW   = NB * BW;
    localparam int              c_CW   = $clog2(NB);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(NB - 1);
    localparam logic [c_CW-1:0] c_ONE  = c_CW'(1);

    localparam logic [0:0] c_IDLE = 1'b0;
    localparam logic [0:0] c_XFER = 1'b1;

    logic [0:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [c_DW-1:0] r_text;
    logic            r_overrun;

    logic [c_DW-1:0] w_next_text;
    logic [c_DW-1:0] w_shifted;
    logic            w_xfer;
    logic            w_at_last;
    logic            w_accept_last;

    // Final AddRoundKey: plain bitwise XOR, only sampled on the done edge.
    assign w_next_text   = sa_i ^ w_i;

    assign w_xfer        = (r_state == c_XFER);
    assign w_at_last     = (r_cnt == c_LAST);
    assign w_accept_last = w_xfer && out_ready && w_at_last;

    // Left-shifting by whole bytes brings the byte selected by the counter to
    // the top, giving MSB-first order without a wide indexed part-select.
    assign w_shifted = r_text << (BW * r_cnt);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= '0;
            r_text    <= '0;
            r_overrun <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (done) begin
                        r_text  <= w_next_text;
                        r_cnt   <= '0;
                        r_state <= c_XFER;
                    end
                end
                c_XFER: begin
                    if (out_ready) begin
                        if (w_at_last) begin
                            r_cnt <= '0;
                            // A strobe coinciding with the last acceptance
                            // chains the next block with no bubble cycle.
                            if (done) begin
                                r_text <= w_next_text;
                            end else begin
                                r_state <= c_IDLE;
                            end
                        end else begin
                            r_cnt <= r_cnt + c_ONE;
                        end
                    end
                    // Any other strobe during unload is dropped; the held
                    // block stays intact and the loss is flagged until reset.
                    if (done && !w_accept_last) begin
                        r_overrun <= 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // All outputs decode registered state only; no input reaches an output
    // combinationally.
    assign out_valid = w_xfer;
    assign busy      = w_xfer;
    assign out_last  = w_xfer && w_at_last;
    assign text_out  = w_xfer ? w_shifted[c_DW-1 -: BW] : '0;
    assign overrun   = r_overrun;

endmodule
`default_nettype wire
